// File: rtl/neurocore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neurocore_pkg
// Description : Shared constants and types for the LIF neuron array: config
//               addresses, update FSM state encoding and reset defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package neurocore_pkg;

    localparam logic [1:0] CFG_THRESH = 2'd0;
    localparam logic [1:0] CFG_LEAK   = 2'd1;
    localparam logic [1:0] CFG_REFRAC = 2'd2;
    localparam logic [1:0] CFG_VRESET = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UPDATE  = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    localparam int RST_THRESHOLD = 100;
    localparam int RST_LEAK      = 2;
    localparam int RST_REFRAC    = 2;
    localparam int RST_VRESET    = 0;

endpackage
`default_nettype wire

// File: rtl/lif_update.sv
`default_nettype none
// ============================================================================
// Module      : lif_update
// Description : Combinational single-neuron leaky integrate-and-fire step.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_update #(
    parameter int V_WIDTH   = 8,
    parameter int REF_WIDTH = 4
) (
    input  logic [V_WIDTH-1:0]   v,
    input  logic [V_WIDTH-1:0]   acc,
    input  logic [REF_WIDTH-1:0] ref_cnt,
    input  logic [V_WIDTH-1:0]   threshold,
    input  logic [2:0]           leak_shift,
    input  logic [REF_WIDTH-1:0] refrac_period,
    input  logic [V_WIDTH-1:0]   v_reset,
    output logic [V_WIDTH-1:0]   v_next,
    output logic [REF_WIDTH-1:0] ref_next,
    output logic                 spike
);

    logic [V_WIDTH:0]   w_leaked;
    logic [V_WIDTH:0]   w_sum;
    logic [V_WIDTH-1:0] w_vn;

    // One extra bit holds the leak+integrate result before saturation.
    assign w_leaked = {1'b0, v} - ({1'b0, v} >> leak_shift);
    assign w_sum    = w_leaked + {1'b0, acc};
    assign w_vn     = w_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : w_sum[V_WIDTH-1:0];

    always_comb begin
        v_next   = w_vn;
        ref_next = '0;
        spike    = 1'b0;
        if (ref_cnt != '0) begin
            ref_next = ref_cnt - 1'b1;
            v_next   = v_reset;
        end else if (w_vn >= threshold) begin
            spike    = 1'b1;
            v_next   = v_reset;
            ref_next = refrac_period;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron_array
// Description : Time-multiplexed array of N LIF neurons, one update per cycle
//               after a step pulse. Optional macro SPIKE_COUNT_EN adds
//               per-neuron saturating spike counters on dbg_count.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
    import neurocore_pkg::*;
#(
    parameter  int N_NEURONS = 4,
    parameter  int V_WIDTH   = 8,
    parameter  int REF_WIDTH = 4,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [V_WIDTH-1:0]   cfg_data,
    input  logic                 cur_we,
    input  logic [IDX_W-1:0]     cur_idx,
    input  logic [V_WIDTH-1:0]   cur_data,
    input  logic                 step,
    output logic                 busy,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spike_valid,
    input  logic [IDX_W-1:0]     dbg_idx,
    output logic [V_WIDTH-1:0]   dbg_vmem,
    output logic [7:0]           dbg_count
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_NEURONS - 1);

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [N_NEURONS-1:0]   r_work;
    logic [N_NEURONS-1:0]   r_spikes;
    logic                   r_spike_valid;
    logic [V_WIDTH-1:0]     r_threshold;
    logic [2:0]             r_leak_shift;
    logic [REF_WIDTH-1:0]   r_refrac;
    logic [V_WIDTH-1:0]     r_v_reset;
    logic [V_WIDTH-1:0]     r_vmem [N_NEURONS];
    logic [V_WIDTH-1:0]     r_acc  [N_NEURONS];
    logic [REF_WIDTH-1:0]   r_ref  [N_NEURONS];

    logic [V_WIDTH-1:0]     w_v_next;
    logic [REF_WIDTH-1:0]   w_ref_next;
    logic                   w_spike;
    logic [N_NEURONS-1:0]   w_spike_vec;

    lif_update #(
        .V_WIDTH   (V_WIDTH),
        .REF_WIDTH (REF_WIDTH)
    ) u_lif_update (
        .v             (r_vmem[r_idx]),
        .acc           (r_acc[r_idx]),
        .ref_cnt       (r_ref[r_idx]),
        .threshold     (r_threshold),
        .leak_shift    (r_leak_shift),
        .refrac_period (r_refrac),
        .v_reset       (r_v_reset),
        .v_next        (w_v_next),
        .ref_next      (w_ref_next),
        .spike         (w_spike)
    );

    assign w_spike_vec = w_spike ? ({{(N_NEURONS-1){1'b0}}, 1'b1} << r_idx) : '0;

    // The published vector is loaded on the way into PUBLISH so it is visible
    // in the same cycle as the valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_work        <= '0;
            r_spikes      <= '0;
            r_spike_valid <= 1'b0;
            r_threshold   <= V_WIDTH'(RST_THRESHOLD);
            r_leak_shift  <= 3'(RST_LEAK);
            r_refrac      <= REF_WIDTH'(RST_REFRAC);
            r_v_reset     <= V_WIDTH'(RST_VRESET);
            for (int j = 0; j < N_NEURONS; j++) begin
                r_vmem[j] <= '0;
                r_ref[j]  <= '0;
            end
        end else begin
            r_spike_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        case (cfg_addr)
                            CFG_THRESH: r_threshold  <= cfg_data;
                            CFG_LEAK:   r_leak_shift <= cfg_data[2:0];
                            CFG_REFRAC: r_refrac     <= cfg_data[REF_WIDTH-1:0];
                            default:    r_v_reset    <= cfg_data;
                        endcase
                    end
                    if (step) begin
                        r_state <= S_UPDATE;
                        r_idx   <= '0;
                        r_work  <= '0;
                    end
                end
                S_UPDATE: begin
                    r_vmem[r_idx] <= w_v_next;
                    r_ref[r_idx]  <= w_ref_next;
                    if (r_idx == c_last_idx) begin
                        r_state       <= S_PUBLISH;
                        r_spikes      <= r_work | w_spike_vec;
                        r_spike_valid <= 1'b1;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                        r_work <= r_work | w_spike_vec;
                    end
                end
                S_PUBLISH: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // The neuron being updated takes only a same-cycle injection; its old
    // accumulator value is consumed by the datapath.
    for (genvar j = 0; j < N_NEURONS; j++) begin : g_acc
        logic             w_hit;
        logic             w_consume;
        logic [V_WIDTH:0] w_acc_sum;

        assign w_hit     = cur_we && (cur_idx == IDX_W'(j));
        assign w_consume = (r_state == S_UPDATE) && (r_idx == IDX_W'(j));
        assign w_acc_sum = {1'b0, r_acc[j]} + {1'b0, cur_data};

        always_ff @(posedge clk) begin
            if (!rst_n)
                r_acc[j] <= '0;
            else if (w_consume)
                r_acc[j] <= w_hit ? cur_data : '0;
            else if (w_hit)
                r_acc[j] <= w_acc_sum[V_WIDTH] ? {V_WIDTH{1'b1}} : w_acc_sum[V_WIDTH-1:0];
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [7:0] r_count [N_NEURONS];

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_spike_count
        always_ff @(posedge clk) begin
            if (!rst_n)
                r_count[j] <= '0;
            else if ((r_state == S_UPDATE) && (r_idx == IDX_W'(j)) && w_spike
                     && (r_count[j] != 8'hFF))
                r_count[j] <= r_count[j] + 8'd1;
        end
    end

    assign dbg_count = r_count[dbg_idx];
`else
    assign dbg_count = 8'd0;
`endif

    assign busy        = (r_state != S_IDLE);
    assign spikes      = r_spikes;
    assign spike_valid = r_spike_valid;
    assign dbg_vmem    = r_vmem[dbg_idx];

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron_array
// Description : Directed self-checking bench for lif_neuron_array (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_array;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       cur_we = 1'b0;
    logic [1:0] cur_idx = '0;
    logic [7:0] cur_data = '0;
    logic       step = 1'b0;
    logic       busy;
    logic [3:0] spikes;
    logic       spike_valid;
    logic [1:0] dbg_idx = '0;
    logic [7:0] dbg_vmem;
    logic [7:0] dbg_count;

    int checks = 0;
    int failures = 0;

    lif_neuron_array #(.N_NEURONS(N), .V_WIDTH(8), .REF_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cur_we      (cur_we),
        .cur_idx     (cur_idx),
        .cur_data    (cur_data),
        .step        (step),
        .busy        (busy),
        .spikes      (spikes),
        .spike_valid (spike_valid),
        .dbg_idx     (dbg_idx),
        .dbg_vmem    (dbg_vmem),
        .dbg_count   (dbg_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input logic [1:0] idx, input logic [7:0] val);
        cur_we = 1'b1; cur_idx = idx; cur_data = val;
        tick();
        cur_we = 1'b0;
    endtask

    task automatic write_cfg(input logic [1:0] addr, input logic [7:0] val);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic check_vmem(input string tag, input logic [1:0] idx, input logic [7:0] exp_v);
        dbg_idx = idx;
        #1;
        check_eq(tag, {24'd0, dbg_vmem}, {24'd0, exp_v});
    endtask

    task automatic run_step(input string tag, input logic [3:0] exp_spk);
        int lat;
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (!spike_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 32'd5);
        check_eq({tag, "_spk"}, {28'd0, spikes}, {28'd0, exp_spk});
        tick();
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;

        // 1: reset and idle
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("rst_spikes", {28'd0, spikes}, 32'd0);
        check_eq("rst_valid", {31'd0, spike_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < N; i++) check_vmem("rst_vmem", 2'(i), 8'd0);
        check_eq("rst_count", {24'd0, dbg_count}, 32'd0);

        // 2: sub-threshold integrate then leak
        inject(2'd0, 8'd60);
        run_step("s2a", 4'b0000);
        check_vmem("s2a_v0", 2'd0, 8'd60);
        run_step("s2b", 4'b0000);
        check_vmem("s2b_v0", 2'd0, 8'd45);

        // 3: spike, refractory, spike again
        inject(2'd1, 8'd120);
        run_step("s3a", 4'b0010);
        check_vmem("s3a_v1", 2'd1, 8'd0);
        check_vmem("s3a_v0", 2'd0, 8'd34);
        inject(2'd1, 8'd200);
        run_step("s3b", 4'b0000);
        check_vmem("s3b_v1", 2'd1, 8'd0);
        inject(2'd1, 8'd200);
        run_step("s3c", 4'b0000);
        inject(2'd1, 8'd200);
        run_step("s3d", 4'b0010);
        check_vmem("s3d_v0", 2'd0, 8'd15);

        // 4: accumulator saturation against the maximum threshold
        write_cfg(2'd0, 8'd255);
        inject(2'd2, 8'd200);
        inject(2'd2, 8'd200);
        run_step("s4", 4'b0100);
        check_vmem("s4_v2", 2'd2, 8'd0);
        dbg_idx = 2'd2;
        #1;
`ifdef SPIKE_COUNT_EN
        check_eq("s4_count", {24'd0, dbg_count}, 32'd1);
`else
        check_eq("s4_count", {24'd0, dbg_count}, 32'd0);
`endif

        // 5a: back-to-back step pulses give a single publish
        pulses = 0;
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (spike_valid) pulses++;
            tick();
        end
        check_eq("s5_pulses", pulses, 32'd1);
        check_eq("s5_spk", {28'd0, spikes}, 32'd0);

        // 5b: injection during n3's own update cycle lands in the next step
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();
        inject(2'd3, 8'd50);
        repeat (3) tick();
        check_eq("s5b_idle", {31'd0, busy}, 32'd0);
        check_vmem("s5b_v3_now", 2'd3, 8'd0);
        run_step("s5c", 4'b0000);
        check_vmem("s5c_v3_next", 2'd3, 8'd50);

        // 6: reset in the middle of an update
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("s6_busy", {31'd0, busy}, 32'd0);
        check_eq("s6_valid", {31'd0, spike_valid}, 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            if (spike_valid) pulses++;
            tick();
        end
        check_eq("s6_no_pulse", pulses, 32'd0);
        check_vmem("s6_v0", 2'd0, 8'd0);
        check_vmem("s6_v3", 2'd3, 8'd0);
        dbg_idx = 2'd2;
        #1;
        check_eq("s6_count", {24'd0, dbg_count}, 32'd0);
        // threshold back at 100: 120 must fire
        inject(2'd0, 8'd120);
        run_step("s6_thr", 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Parametrised, time-multiplexed array of N leaky integrate-and-fire neurons for the neurocore top level. Membrane potentials live in a register array. One shared update datapath processes one neuron per cycle after a step pulse. Input currents accumulate per neuron between steps, and the spike vector is published once per step with a valid pulse. The top-level wrapper maps ui_in/uio_in onto the config and current ports and maps spikes onto uo_out.

Parameters:
N_NEURONS, 4, number of neurons; must be ≥2. IDX_W = $clog2(N_NEURONS) is derived.
V_WIDTH, 8, width of membrane potential, current, threshold and reset potential; unsigned.
REF_WIDTH, 4, width of the refractory counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=threshold, 1=leak_shift, 2=refrac_period, 3=v_reset
cfg_data  in  V_WIDTH  config value; leak_shift uses low 3 bits, refrac_period uses low REF_WIDTH bits
cur_we  in  1  current-inject strobe
cur_idx  in  IDX_W  target neuron
cur_data  in  V_WIDTH  current to add to that neuron's accumulator
step  in  1  start one timestep
busy  out  1  update in progress
spikes  out  N_NEURONS  spike vector of the last completed step
spike_valid  out  1  one-cycle pulse when spikes updates
dbg_idx  in  IDX_W  debug read select
dbg_vmem  out  V_WIDTH  membrane potential of neuron dbg_idx; combinational read of the register
dbg_count  out  8  spike count of neuron dbg_idx; see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all V, accumulators, refractory counters and spikes cleared to 0; busy=0, spike_valid=0.
  - threshold=100, leak_shift=2, refrac_period=2, v_reset=0.
- FSM states IDLE, UPDATE, PUBLISH.
  - IDLE: step=1 → UPDATE with idx=0 and the working spike register cleared.
  - UPDATE: one neuron per cycle; idx increments; after neuron N-1 → PUBLISH.
  - PUBLISH: spikes ← working register, spike_valid=1 for one cycle, → IDLE.
- Latency: step sampled at edge t gives busy=1 for cycles t+1..t+N+1. spike_valid=1 and new spikes are visible in cycle t+N+1. busy=0 from t+N+2.
- step while busy is ignored; no queueing.
- cfg_we while busy is ignored. In IDLE, the write takes effect at the next edge.
- Accumulator add: acc[cur_idx] ← min(acc + cur_data, 2^V_WIDTH−1). Accepted in any state.
- Neuron update for neuron i in UPDATE:
  - If ref[i]≠0: ref[i]−1, V[i]=v_reset, no spike, acc consumed.
  - Otherwise: Vn = V − (V>>leak_shift) + acc, computed in V_WIDTH+1 bits and saturated to 2^V_WIDTH−1.
    - If Vn ≥ threshold: spike bit i=1, V[i]=v_reset, ref[i]=refrac_period.
    - Else V[i]=Vn.
- Consumption: in the cycle neuron i is processed, acc[i] ← (cur_we && cur_idx==i) ? cur_data : 0. The new current counts toward the next step; the old acc is used now.
- threshold=0 makes every non-refractory neuron spike every step. leak_shift=0 zeroes V before adding acc (full leak).
- Reset mid-UPDATE: everything returns to reset values; no spike_valid pulse is issued.

Optional Feature:
- Macro SPIKE_COUNT_EN.
- Defined: per-neuron 8-bit saturating spike counters (stop at 255), cleared by reset. dbg_count = count[dbg_idx].
- Not defined: no counter registers; dbg_count is tied to 0.

Decomposition:
- neurocore_pkg holds:
  - cfg address constants CFG_THRESH/CFG_LEAK/CFG_REFRAC/CFG_VRESET;
  - FSM state enum;
  - reset-default constants.
- Sub-module lif_update: a purely combinational single-neuron datapath.
  - Inputs: V, acc, ref, threshold, leak_shift, refrac_period, v_reset.
  - Outputs: next V, next ref, spike.
- The array module owns the storage, the FSM and the accumulators.

Test Plan:
1. Reset, then idle for 5 cycles → spikes=0, spike_valid=0, busy=0, every dbg_vmem=0.
2. Inject 60 to n0, step → spike_valid 5 cycles after step (N=4), no spike, dbg_vmem(0)=60. Step again without input → 45.
3. Inject 120 to n1, step → spikes=4'b0010, V1=0. Then inject 200 each step: steps 2–3 give no spike (refractory), step 4 gives spikes=4'b0010.
4. Set threshold=255 and inject 200 twice to n2 (acc saturates 255), then step → spike on n2. With SPIKE_COUNT_EN, dbg_count(2)=1.
5. Pulse step twice back-to-back → only one spike_valid. cur_we to n3 in n3's update cycle → value applied at the following step, not the current one.
6. Deassert rst_n during UPDATE → next cycle busy=0, no spike_valid, V cleared, threshold back to 100.
